// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display scanner: scans NUM_DIGITS digits with an all-off gap between slots.
// Values are double-buffered and committed only at a frame boundary; all outputs are registered.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         enable,
    input  logic                                         load,
    input  logic [4*NUM_DIGITS-1:0]                      value,
    input  logic [NUM_DIGITS-1:0]                        dp_in,
    input  logic                                         lz_blank,
    output logic [3:0]                                   hex_out,
    output logic [NUM_DIGITS-1:0]                        digit_en,
    output logic                                         dp_out,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                         frame_done
);
    localparam int IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SHOW_CYCLES = REFRESH_DIV - GAP_CYCLES;
    localparam int CW          = $clog2(REFRESH_DIV + 1);

    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    commit;
    logic                    last_slot;

    logic [4*NUM_DIGITS-1:0] pending, display;
    logic [NUM_DIGITS-1:0]   dp_pend, dp_disp;
    logic                    pend_valid;

    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    blanked;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        commit    = 1'b0;
        last_slot = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (enable) state_nxt = GAP;
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                    commit    = (idx == '0);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SHOW: begin
                if (cnt == CW'(SHOW_CYCLES - 1)) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    last_slot = (idx == IW'(NUM_DIGITS - 1));
                    idx_nxt   = last_slot ? '0 : idx + IW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Disabling overrides everything: go dark, restart from digit 0, no frame pulse.
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            commit    = 1'b0;
            last_slot = 1'b0;
        end
    end

    // lead_zero[i]: nibbles N-1..i of the displayed value are all zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (display[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (display[4*i +: 4] == 4'd0);
        end
        blanked = lz_blank && (idx != '0) && lead_zero[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            pending    <= '0;
            dp_pend    <= '0;
            pend_valid <= 1'b0;
            display    <= '0;
            dp_disp    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (commit && (load || pend_valid)) begin
                display    <= load ? value : pending;
                dp_disp    <= load ? dp_in : dp_pend;
                pend_valid <= 1'b0;
            end else if (load) begin
                pending    <= value;
                dp_pend    <= dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_out    <= '0;
            digit_en   <= '0;
            dp_out     <= 1'b0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else if (!enable) begin
            digit_en   <= '0;
            dp_out     <= 1'b0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            digit_idx  <= idx;
            frame_done <= last_slot;
            if (state == SHOW) begin
                hex_out  <= display[4*idx +: 4];
                digit_en <= blanked ? '0 : (NUM_DIGITS'(1) << idx);
                dp_out   <= !blanked && dp_disp[idx];
            end else begin
                digit_en <= '0;
                dp_out   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed and randomized bench for seven_seg_scanner (4 digits, 8-cycle slots, 2-cycle gap).
// Expected outputs come from a frame-position model: slot = position/8, gap = first 2 cycles of a slot.
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        reset, enable, load, lz_blank;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  hex_out;
    logic [3:0]  digit_en;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .lz_blank(lz_blank), .hex_out(hex_out), .digit_en(digit_en),
        .dp_out(dp_out), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: mj counts cycles since the scan left IDLE; a frame is 32 cycles.
    bit          mrun = 1'b0;
    int          mj = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_ddp = '0, m_pdp = '0;
    bit          m_pv = 1'b0;
    logic [3:0]  e_hex = '0, e_en = '0;
    logic        e_dp = 1'b0, e_fd = 1'b0;
    logic [1:0]  e_idx = '0;
    int          lit = 0, fds = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int p, d;
        bit blank;
        if (reset) begin
            mrun = 0; mj = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 0;
            e_hex = '0; e_en = '0; e_dp = 0; e_fd = 0; e_idx = '0;
        end else begin
            if (!enable || !mrun) begin
                e_en = '0; e_dp = 0; e_idx = '0; e_fd = 0;
            end else begin
                p = mj % 8;
                d = (mj / 8) % 4;
                e_idx = 2'(d);
                e_fd  = (mj % 32 == 31);
                if (p < 2) begin
                    e_en = '0; e_dp = 0;
                end else begin
                    blank = lz_blank && d > 0 && ((m_disp >> (4 * d)) == 16'd0);
                    e_hex = 4'((m_disp >> (4 * d)) & 16'hF);
                    e_en  = blank ? 4'd0 : 4'(1 << d);
                    e_dp  = !blank && m_ddp[d];
                end
            end
            if (!enable) mrun = 0;
            else if (!mrun) begin mrun = 1; mj = 0; end
            else mj++;
            if (enable && mrun && (mj % 32 == 2) && (load || m_pv)) begin
                m_disp = load ? value : m_pend;
                m_ddp  = load ? dp_in : m_pdp;
                m_pv   = 0;
            end else if (load) begin
                m_pend = value; m_pdp = dp_in; m_pv = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("digit_en", 16'(digit_en), 16'(e_en));
        chk("hex_out", 16'(hex_out), 16'(e_hex));
        chk("dp_out", 16'(dp_out), 16'(e_dp));
        chk("digit_idx", 16'(digit_idx), 16'(e_idx));
        chk("frame_done", 16'(frame_done), 16'(e_fd));
        if (digit_en != 4'd0) lit++;
        if (frame_done) fds++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        value = v; dp_in = dp; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Advance until the model's frame position equals target (bounded).
    task automatic wait_phase(input int target);
        int n = 0;
        while (!(mrun && (mj % 32 == target)) && n < 100) begin
            step();
            n++;
        end
        checks++;
        assert (n < 100) else begin
            failures++;
            $error("FAIL wait_phase observed=%0d cycles expected=<100", n);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; lz_blank = 1'b0;
        value = '0; dp_in = '0;
        run(3);

        reset = 1'b0; enable = 1'b1;
        wait_phase(0);
        fds = 0;
        run(64);
        chk("fd_per_64", 16'(fds), 16'd2);

        // Mid-frame load must not tear the frame in progress.
        wait_phase(12);
        do_load(16'h1A3F, 4'b0000);
        run(60);

        lz_blank = 1'b1;
        do_load(16'h0005, 4'b0000);
        wait_phase(2);
        lit = 0;
        run(32);
        chk("lit_0005", 16'(lit), 16'd6);
        do_load(16'h0000, 4'b0000);
        wait_phase(2);
        lit = 0;
        run(32);
        chk("lit_0000", 16'(lit), 16'd6);

        lz_blank = 1'b0;
        do_load(16'h1234, 4'b0100);
        run(50);
        lz_blank = 1'b1;
        do_load(16'h0001, 4'b0100);
        run(50);

        lz_blank = 1'b0;
        wait_phase(5);
        do_load(16'h1111, 4'b0001);
        run(3);
        do_load(16'h2222, 4'b0010);
        run(40);

        // Load arriving on the commit edge is shown in that same frame.
        wait_phase(1);
        do_load(16'hC0DE, 4'b1000);
        run(34);

        wait_phase(20);
        enable = 1'b0;
        step();
        chk("dark_after_disable", 16'(digit_en), 16'd0);
        run(3);
        enable = 1'b1;
        run(40);

        wait_phase(4);
        do_load(16'hBEEF, 4'b1111);
        wait_phase(12);
        reset = 1'b1;
        step();
        chk("rst_mid_en", 16'(digit_en), 16'd0);
        chk("rst_mid_hex", 16'(hex_out), 16'd0);
        reset = 1'b0;
        run(40);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) lz_blank = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                value = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
                dp_in = 4'($urandom);
                load  = 1'b1;
            end
            step();
            load = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
